// File: rtl/uart_rx.sv
// UART receive stage: 8 data bits LSB first, even parity, one stop bit,
// mid-bit sampling at BR_clock_cycles clocks per bit, one-cycle rx_valid strobe.
module uart_rx #(
  parameter int BR_count_width  = 5,
  parameter int BR_clock_cycles = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [BR_count_width-1:0] HALF_M1  = BR_count_width'(BR_clock_cycles/2 - 1);
  localparam logic [BR_count_width-1:0] BIT_LAST = BR_count_width'(BR_clock_cycles - 1);

  logic                      r_s1;
  logic                      r_rx_s;
  logic [2:0]                r_state;
  logic [BR_count_width-1:0] r_cnt;
  logic [2:0]                r_bit_idx;
  logic                      r_armed;
  logic [7:0]                r_shift;
  logic                      r_pbit;
  logic [7:0]                r_data;
  logic                      r_valid;
  logic                      r_perr;
  logic                      r_ferr;

  logic w_wrap;
  logic w_mid;

  assign w_wrap = (r_cnt == BIT_LAST);
  assign w_mid  = (r_cnt == HALF_M1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1      <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_armed   <= 1'b1;
      r_shift   <= 8'h00;
      r_pbit    <= 1'b0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_s1    <= rx;
      r_rx_s  <= r_s1;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // armed is cleared by a bad stop bit so a held-low break cannot retrigger
          if (r_armed && !r_rx_s) begin
            r_state <= S_START;
          end else if (!r_armed && r_rx_s) begin
            r_armed <= 1'b1;
          end
        end
        S_START: begin
          if (w_mid) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_wrap) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_rx_s;
            r_bit_idx          <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= S_PARITY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_pbit  <= r_rx_s;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_wrap) begin
            // commit lands mid-stop-bit so back-to-back start edges are caught
            r_cnt   <= '0;
            r_data  <= r_shift;
            r_perr  <= (^r_shift) ^ r_pbit;
            r_ferr  <= ~r_rx_s;
            r_valid <= 1'b1;
            r_armed <= r_rx_s;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage: the downstream counterpart of the team's UART transmitter, consuming its serial line. It deserialises 11-bit frames (start, 8 data bits LSB first, even parity, stop) at `BR_clock_cycles` clocks per bit. It samples every bit at mid-bit and presents the received byte with a one-cycle valid strobe plus parity and framing error flags. It sits between the serial pin and the parallel consumer logic, on the same clock as the transmitter.

## Interface
- `BR_count_width`, 5: width of the baud-rate counter; must satisfy 2^width ≥ `BR_clock_cycles`.
- `BR_clock_cycles`, 20: clocks per bit; even, ≥ 4. HALF = `BR_clock_cycles`/2.
- `clock`  in  1  single system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line, idle high; asynchronous to `clock`.
- `data_out`  out  8  last received byte; holds until the next completed frame.
- `rx_valid`  out  1  one-cycle pulse when a frame completes, good or bad.
- `parity_err`  out  1  parity error of the last frame; updated with `rx_valid`.
- `frame_err`  out  1  stop bit sampled 0 in the last frame; updated with `rx_valid`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Synchroniser: two flops `rx` → s1 → rx_s. Both reset to 1. All decisions use rx_s only.
- Reset, applied at any time including mid-frame:
  - state = IDLE, counter = 0, bit index = 0, armed = 1, sync flops = 1.
  - `data_out` = 0x00, `rx_valid` = `parity_err` = `frame_err` = `busy` = 0.
  - A partial frame is discarded and no `rx_valid` is produced.
- State machine:
  - IDLE: counter held at 0. If armed and rx_s = 0, go to START with counter = 0. If not armed, set armed when rx_s = 1.
  - START: counter increments. When counter = HALF-1, sample rx_s.
    - rx_s = 0: go to DATA, counter = 0, bit index = 0.
    - rx_s = 1: glitch. Return to IDLE with no strobe and no flag change.
  - DATA: counter increments and wraps to 0 at `BR_clock_cycles`-1. At the wrap, rx_s goes into shift register bit [bit index], LSB first, and bit index increments. After bit 7 is sampled, go to PARITY.
  - PARITY: at the wrap, capture rx_s as pbit and go to STOP.
  - STOP: at the wrap, sample rx_s and commit on the next clock edge:
    - `data_out` ← shift register
    - `parity_err` ← (^shift) ^ pbit; expected pbit = XOR of the data bits.
    - `frame_err` ← ~rx_s
    - `rx_valid` ← 1 for exactly one cycle
    - then go to IDLE.
  - If the stop bit is 0, armed clears. A held-low line (break) cannot start a new frame until rx_s returns to 1.
  - Unused encodings go to IDLE.
- Counter arithmetic is modulo `BR_clock_cycles` only. It never overflows `BR_count_width`.
- Error flags are per-frame, not sticky. Each commit overwrites both flags.

## Timing
- T = first cycle with state = START. This is 2 clocks after the first edge that registers `rx` = 0 into s1.
- Sample instants:
  - start bit: T+HALF-1
  - data bit k (k = 0..7): T+HALF-1+(k+1)·`BR_clock_cycles`
  - parity: T+HALF-1+9·`BR_clock_cycles`
  - stop: T+HALF-1+10·`BR_clock_cycles`
- `rx_valid`, `data_out` and both flags change at T+HALF+10·`BR_clock_cycles`, which is T+210 at the defaults.
- `busy` is high from T through the stop-sample cycle. It is low in the `rx_valid` cycle.
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle after the commit, which is mid-stop-bit. Zero idle bits between frames is supported.
- Glitch rejection: a low pulse shorter than HALF clocks on rx_s produces no strobe.

## Test plan
- Frame 0xA5 with pbit 0 and stop 1, at 20 clocks/bit → exactly one `rx_valid` at T+210; `data_out` = 0xA5, `parity_err` = 0, `frame_err` = 0.
- Frame 0x01 with pbit 0 → `data_out` = 0x01, `parity_err` = 1, `frame_err` = 0. The next good frame 0x03 with pbit 0 clears `parity_err`.
- Frame 0x3C with stop bit 0, line then held low for 100 clocks → `frame_err` = 1 and one `rx_valid`. No further `rx_valid` until the line returns high and a new start arrives.
- `rx` low for 5 clocks, then high → no `rx_valid`, `busy` returns to 0, all outputs unchanged.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `rx_valid` pulses 220 clocks apart; `data_out` = 0x00, then 0xFF, with no errors.
- `reset` asserted while DATA bit 4 is being received, then a clean frame 0x5A → no strobe for the aborted frame; outputs reset to 0; 0x5A is received correctly.
